// File: rtl/frmpool_sram_sp_if.sv
// Bus bundle for the frame-pool single-port SRAM model: access controls,
// margin pins and the registered read-data return.
interface frmpool_sram_sp_if #(
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned WIDTH     = 16
);
  logic                 CSB;
  logic [WIDTH-1:0]     WEB;
  logic [ADDR_BITS-1:0] A;
  logic [WIDTH-1:0]     DI;
  logic                 DVSE;
  logic [3:0]           DVS;
  logic [WIDTH-1:0]     DO;
  logic                 DO_VLD;

  modport master (
    output CSB, WEB, A, DI, DVSE, DVS,
    input  DO, DO_VLD
  );

  modport slave (
    input  CSB, WEB, A, DI, DVSE, DVS,
    output DO, DO_VLD
  );
endinterface

// File: rtl/frmpool_sram_sp.sv
// Single-port synchronous SRAM model with per-bit active-low write mask,
// held read data and a one-cycle read-valid pulse.
module frmpool_sram_sp #(
  parameter int unsigned DEPTH     = 49,
  parameter int unsigned ADDR_BITS = 6,
  parameter int unsigned WIDTH     = 16
) (
  input  logic              clk,
  input  logic              rst,
  frmpool_sram_sp_if.slave  bus
);

  localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] do_q;
  logic             do_vld_q;
  logic             in_range;
  logic             rd_en;
  logic             wr_en;
  logic             unused_margin;

  assign in_range = (bus.A <= LastAddr);
  assign rd_en    = !rst && !bus.CSB && (&bus.WEB);
  assign wr_en    = !rst && !bus.CSB && !(&bus.WEB) && in_range;

  // Margin-control pins have no functional effect in this model.
  assign unused_margin = ^{bus.DVSE, bus.DVS};

  // No reset on the array: contents survive reset and start uninitialised.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[bus.A] <= (mem[bus.A] & bus.WEB) | (bus.DI & ~bus.WEB);
    end
  end

  // DO only moves on read edges, so the last read value is held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_q     <= '0;
      do_vld_q <= 1'b0;
    end else if (rd_en) begin
      do_q     <= in_range ? mem[bus.A] : '0;
      do_vld_q <= 1'b1;
    end else begin
      do_vld_q <= 1'b0;
    end
  end

  assign bus.DO     = do_q;
  assign bus.DO_VLD = do_vld_q;

endmodule

// File: tb/tb_frmpool_sram_sp.sv
// Scoreboard bench for frmpool_sram_sp: expectations are queued as each
// access is driven and compared one cycle later against DO/DO_VLD.
module tb_frmpool_sram_sp;

  typedef struct {
    logic [15:0] data;
    logic        vld;
    bit          neq;
  } exp_t;

  typedef struct {
    logic        r;
    logic        csb;
    logic [15:0] web;
    logic [5:0]  a;
    logic [15:0] di;
    logic [15:0] exp_do;
    logic        exp_vld;
  } stim_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  frmpool_sram_sp_if #(.ADDR_BITS(6), .WIDTH(16)) bus ();

  frmpool_sram_sp #(
    .DEPTH     (49),
    .ADDR_BITS (6),
    .WIDTH     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Drive one access, let the edge happen, and settle just past it.
  task automatic step(input logic r, input logic csb, input logic [15:0] web,
                      input logic [5:0] a, input logic [15:0] di);
    rst      = r;
    bus.CSB  = csb;
    bus.WEB  = web;
    bus.A    = a;
    bus.DI   = di;
    bus.DVSE = 1'($urandom);
    bus.DVS  = 4'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t t [5];
    exp_t  e;
    t[0] = '{1'b1, 1'b1, 16'hFFFF, 6'd0, 16'h0, 16'h0000, 1'b0};
    t[1] = '{1'b1, 1'b1, 16'hFFFF, 6'd0, 16'h0, 16'h0000, 1'b0};
    t[2] = '{1'b0, 1'b1, 16'hFFFF, 6'd3, 16'h0, 16'h0000, 1'b0};
    t[3] = '{1'b0, 1'b1, 16'hFFFF, 6'd5, 16'h0, 16'h0000, 1'b0};
    t[4] = '{1'b0, 1'b1, 16'h0000, 6'd9, 16'h0, 16'h0000, 1'b0};
    foreach (t[i]) begin
      sb.push_back('{t[i].exp_do, t[i].exp_vld, 1'b0});
      step(t[i].r, t[i].csb, t[i].web, t[i].a, t[i].di);
      e = sb.pop_front();
      checks++;
      if (bus.DO !== e.data || bus.DO_VLD !== e.vld) begin
        failures++;
        $display("FAIL reset[%0d]: got DO=%h VLD=%b, want DO=%h VLD=%b",
                 i, bus.DO, bus.DO_VLD, e.data, e.vld);
      end
    end
  endtask

  task automatic test_write_read();
    stim_t t [3];
    exp_t  e;
    t[0] = '{1'b0, 1'b0, 16'h0000, 6'd5, 16'hA5C3, 16'h0000, 1'b0};
    t[1] = '{1'b0, 1'b0, 16'hFFFF, 6'd5, 16'h0000, 16'hA5C3, 1'b1};
    t[2] = '{1'b0, 1'b1, 16'hFFFF, 6'd5, 16'h0000, 16'hA5C3, 1'b0};
    foreach (t[i]) begin
      sb.push_back('{t[i].exp_do, t[i].exp_vld, 1'b0});
      step(t[i].r, t[i].csb, t[i].web, t[i].a, t[i].di);
      e = sb.pop_front();
      checks++;
      if (bus.DO !== e.data || bus.DO_VLD !== e.vld) begin
        failures++;
        $display("FAIL write_read[%0d]: got DO=%h VLD=%b, want DO=%h VLD=%b",
                 i, bus.DO, bus.DO_VLD, e.data, e.vld);
      end
    end
  endtask

  task automatic test_masked_write();
    stim_t t [2];
    exp_t  e;
    t[0] = '{1'b0, 1'b0, 16'hFF00, 6'd5, 16'h0000, 16'hA5C3, 1'b0};
    t[1] = '{1'b0, 1'b0, 16'hFFFF, 6'd5, 16'h0000, 16'hA500, 1'b1};
    foreach (t[i]) begin
      sb.push_back('{t[i].exp_do, t[i].exp_vld, 1'b0});
      step(t[i].r, t[i].csb, t[i].web, t[i].a, t[i].di);
      e = sb.pop_front();
      checks++;
      if (bus.DO !== e.data || bus.DO_VLD !== e.vld) begin
        failures++;
        $display("FAIL masked_write[%0d]: got DO=%h VLD=%b, want DO=%h VLD=%b",
                 i, bus.DO, bus.DO_VLD, e.data, e.vld);
      end
    end
  endtask

  task automatic test_out_of_range();
    stim_t t [7];
    exp_t  e;
    t[0] = '{1'b0, 1'b0, 16'h0000, 6'd1,  16'h5A5A, 16'hA500, 1'b0};
    t[1] = '{1'b0, 1'b0, 16'h0000, 6'd48, 16'h1234, 16'hA500, 1'b0};
    t[2] = '{1'b0, 1'b0, 16'h0000, 6'd50, 16'hFFFF, 16'hA500, 1'b0};
    t[3] = '{1'b0, 1'b0, 16'hFFFF, 6'd48, 16'h0000, 16'h1234, 1'b1};
    t[4] = '{1'b0, 1'b0, 16'hFFFF, 6'd50, 16'h0000, 16'h0000, 1'b1};
    t[5] = '{1'b0, 1'b0, 16'hFFFF, 6'd1,  16'h0000, 16'h5A5A, 1'b1};
    t[6] = '{1'b0, 1'b0, 16'hFFFF, 6'd63, 16'h0000, 16'h0000, 1'b1};
    foreach (t[i]) begin
      sb.push_back('{t[i].exp_do, t[i].exp_vld, 1'b0});
      step(t[i].r, t[i].csb, t[i].web, t[i].a, t[i].di);
      e = sb.pop_front();
      checks++;
      if (bus.DO !== e.data || bus.DO_VLD !== e.vld) begin
        failures++;
        $display("FAIL out_of_range[%0d]: got DO=%h VLD=%b, want DO=%h VLD=%b",
                 i, bus.DO, bus.DO_VLD, e.data, e.vld);
      end
    end
  endtask

  task automatic test_hold();
    stim_t t [4];
    exp_t  e;
    t[0] = '{1'b0, 1'b0, 16'hFFFF, 6'd5, 16'h0000, 16'hA500, 1'b1};
    t[1] = '{1'b0, 1'b0, 16'h0000, 6'd5, 16'h7777, 16'hA500, 1'b0};
    t[2] = '{1'b0, 1'b0, 16'hFFFF, 6'd5, 16'h0000, 16'h7777, 1'b1};
    t[3] = '{1'b0, 1'b1, 16'h0000, 6'd5, 16'h1111, 16'h7777, 1'b0};
    foreach (t[i]) begin
      sb.push_back('{t[i].exp_do, t[i].exp_vld, 1'b0});
      step(t[i].r, t[i].csb, t[i].web, t[i].a, t[i].di);
      e = sb.pop_front();
      checks++;
      if (bus.DO !== e.data || bus.DO_VLD !== e.vld) begin
        failures++;
        $display("FAIL hold[%0d]: got DO=%h VLD=%b, want DO=%h VLD=%b",
                 i, bus.DO, bus.DO_VLD, e.data, e.vld);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] model [8];
    logic [15:0] last_do;
    exp_t        e;
    last_do = 16'h7777;
    for (int i = 0; i < 8; i++) begin
      model[i] = 16'($urandom);
      sb.push_back('{last_do, 1'b0, 1'b0});
      step(1'b0, 1'b0, 16'h0000, 6'(10 + i), model[i]);
      e = sb.pop_front();
      checks++;
      if (bus.DO !== e.data || bus.DO_VLD !== e.vld) begin
        failures++;
        $display("FAIL b2b_write[%0d]: got DO=%h VLD=%b, want DO=%h VLD=%b",
                 i, bus.DO, bus.DO_VLD, e.data, e.vld);
      end
    end
    for (int i = 0; i < 8; i++) begin
      last_do = model[i];
      sb.push_back('{last_do, 1'b1, 1'b0});
      step(1'b0, 1'b0, 16'hFFFF, 6'(10 + i), 16'h0000);
      e = sb.pop_front();
      checks++;
      if (bus.DO !== e.data || bus.DO_VLD !== e.vld) begin
        failures++;
        $display("FAIL b2b_read[%0d]: got DO=%h VLD=%b, want DO=%h VLD=%b",
                 i, bus.DO, bus.DO_VLD, e.data, e.vld);
      end
    end
  endtask

  task automatic test_reset_blocks_write();
    exp_t e;
    sb.push_back('{16'h0000, 1'b0, 1'b0});
    step(1'b1, 1'b0, 16'h0000, 6'd7, 16'hBEEF);
    e = sb.pop_front();
    checks++;
    if (bus.DO !== e.data || bus.DO_VLD !== e.vld) begin
      failures++;
      $display("FAIL rst_write_cycle: got DO=%h VLD=%b, want DO=%h VLD=%b",
               bus.DO, bus.DO_VLD, e.data, e.vld);
    end
    // Word 7 was never written, so anything but BEEF is acceptable.
    sb.push_back('{16'hBEEF, 1'b1, 1'b1});
    step(1'b0, 1'b0, 16'hFFFF, 6'd7, 16'h0000);
    e = sb.pop_front();
    checks++;
    if (bus.DO === e.data || bus.DO_VLD !== e.vld) begin
      failures++;
      $display("FAIL rst_blocks_write: got DO=%h VLD=%b, want DO!=%h VLD=%b",
               bus.DO, bus.DO_VLD, e.data, e.vld);
    end
  endtask

  initial begin
    rst      = 1'b1;
    bus.CSB  = 1'b1;
    bus.WEB  = '1;
    bus.A    = '0;
    bus.DI   = '0;
    bus.DVSE = 1'b0;
    bus.DVS  = '0;
    #2;
    test_reset();
    test_write_read();
    test_masked_write();
    test_out_of_range();
    test_hold();
    test_back_to_back();
    test_reset_blocks_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
